// File: rtl/boot_pkg.sv
// Shared types and constants for the serial boot loader.
// Optional checksum support is enabled with BOOT_LOADER_CHECKSUM_EN.
package boot_pkg;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
  localparam int         CNT_W         = 16;

  typedef enum logic [3:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DAT_LO,
    DAT_HI,
    CS_LO,
    CS_HI,
    RUN,
    ERROR
  } boot_state_t;

endpackage

// File: rtl/boot_loader_byte_pair.sv
// Assembles a low byte and a following high byte into a 16-bit word and
// raises a one-cycle valid strobe in the cycle after the high byte.
module byte_pair (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_byte,
  input  logic        i_lo_en,
  input  logic        i_hi_en,
  output logic [15:0] o_word,
  output logic        o_valid
);

  logic [7:0]  r_lo;
  logic [15:0] r_word;
  logic        r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lo    <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_hi_en;
      if (i_lo_en) r_lo <= i_byte;
      if (i_hi_en) r_word <= {i_byte, r_lo};
    end
  end

  assign o_word  = r_word;
  assign o_valid = r_valid;

endmodule

// File: rtl/boot_loader.sv
// Receives a framed program image over a byte link, writes it to RAM and
// then releases the CPU. Define BOOT_LOADER_CHECKSUM_EN for a trailing checksum.
module boot_loader
  import boot_pkg::*;
#(
  parameter int         MEMWIDTH = 14,
  parameter logic [7:0] MAGIC    = MAGIC_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [MEMWIDTH-1:0] ram_addr,
  output logic [15:0]         ram_wdata,
  output logic                ram_we,
  output logic                cpu_reset,
  output logic                boot_done,
  output logic                boot_error
);

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam boot_state_t AFTER_DATA = CS_LO;
`else
  localparam boot_state_t AFTER_DATA = RUN;
`endif

  boot_state_t         r_state, w_next;
  logic                r_rx_ready, r_cpu_reset, r_boot_done, r_boot_error;
  logic [7:0]          r_len_lo;
  logic [CNT_W-1:0]    r_len, r_index;
  logic [MEMWIDTH-1:0] r_ram_addr;
  logic [15:0]         w_word;
  logic                w_word_valid;
  logic                w_acc, w_magic, w_len_too_big, w_last_word;
  logic [CNT_W-1:0]    w_len_full;

  assign w_acc         = rx_valid && r_rx_ready;
  assign w_magic       = (rx_data == MAGIC);
  assign w_len_full    = {rx_data, r_len_lo};
  assign w_len_too_big = ({16'b0, w_len_full} > (32'd1 << MEMWIDTH));
  assign w_last_word   = ((r_index + 16'd1) == r_len);

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [15:0] r_sum;
  logic [7:0]  r_cs_lo;
  logic        w_cs_match;

  assign w_cs_match = ({rx_data, r_cs_lo} == r_sum);

  // Running sum is fed from the assembled word strobe; it settles before CS_HI can be accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum   <= '0;
      r_cs_lo <= '0;
    end else begin
      if (w_acc && w_magic && (r_state == IDLE || r_state == ERROR))
        r_sum <= '0;
      else if (w_word_valid)
        r_sum <= r_sum + w_word;
      if (w_acc && r_state == CS_LO) r_cs_lo <= rx_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc && w_magic) w_next = LEN_LO;
      LEN_LO:  if (w_acc) w_next = LEN_HI;
      LEN_HI: begin
        if (w_acc) begin
          if (w_len_too_big)          w_next = ERROR;
          else if (w_len_full == '0)  w_next = AFTER_DATA;
          else                        w_next = DAT_LO;
        end
      end
      DAT_LO:  if (w_acc) w_next = DAT_HI;
      DAT_HI:  if (w_acc) w_next = w_last_word ? AFTER_DATA : DAT_LO;
`ifdef BOOT_LOADER_CHECKSUM_EN
      CS_LO:   if (w_acc) w_next = CS_HI;
      CS_HI:   if (w_acc) w_next = w_cs_match ? RUN : ERROR;
`endif
      RUN:     w_next = RUN;
      ERROR:   if (w_acc && w_magic) w_next = LEN_LO;
      default: w_next = IDLE;
    endcase
  end

  // cpu_reset and boot_done follow the current state, so the CPU is released
  // one cycle after the final RAM write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_ready   <= 1'b1;
      r_cpu_reset  <= 1'b1;
      r_boot_done  <= 1'b0;
      r_boot_error <= 1'b0;
      r_len_lo     <= '0;
      r_len        <= '0;
      r_index      <= '0;
      r_ram_addr   <= '0;
    end else begin
      r_rx_ready   <= (w_next != RUN);
      r_cpu_reset  <= (r_state != RUN);
      r_boot_done  <= (r_state == RUN);
      r_boot_error <= (w_next == ERROR);
      if (w_acc) begin
        case (r_state)
          IDLE, ERROR: if (w_magic) r_index <= '0;
          LEN_LO:      r_len_lo <= rx_data;
          LEN_HI:      r_len <= w_len_full;
          DAT_HI: begin
            r_ram_addr <= r_index[MEMWIDTH-1:0];
            r_index    <= r_index + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  byte_pair u_pair (
    .clk     (clk),
    .reset   (reset),
    .i_byte  (rx_data),
    .i_lo_en (w_acc && r_state == DAT_LO),
    .i_hi_en (w_acc && r_state == DAT_HI),
    .o_word  (w_word),
    .o_valid (w_word_valid)
  );

  assign rx_ready   = r_rx_ready;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = w_word;
  assign ram_we     = w_word_valid;
  assign cpu_reset  = r_cpu_reset;
  assign boot_done  = r_boot_done;
  assign boot_error = r_boot_error;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: default build and, when
// BOOT_LOADER_CHECKSUM_EN is defined, the checksum frames too.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        sel;

  logic        rdyA, weA, cpuA, doneA, errA;
  logic [13:0] addrA;
  logic [15:0] wdataA;
  logic        rdyB, weB, cpuB, doneB, errB;
  logic [3:0]  addrB;
  logic [15:0] wdataB;

  logic        rdy, we, cpu, done, err;
  logic [15:0] curAddr, curData;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         q[$];
  wr_t         e;
  int          nCompared = 0;
  int          nMismatched = 0;

  always #5 clk = ~clk;

  boot_loader dutA (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid && !sel),
    .rx_ready(rdyA), .ram_addr(addrA), .ram_wdata(wdataA), .ram_we(weA),
    .cpu_reset(cpuA), .boot_done(doneA), .boot_error(errA)
  );

  boot_loader #(.MEMWIDTH(4)) dutB (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid && sel),
    .rx_ready(rdyB), .ram_addr(addrB), .ram_wdata(wdataB), .ram_we(weB),
    .cpu_reset(cpuB), .boot_done(doneB), .boot_error(errB)
  );

  assign rdy     = sel ? rdyB  : rdyA;
  assign we      = sel ? weB   : weA;
  assign cpu     = sel ? cpuB  : cpuA;
  assign done    = sel ? doneB : doneA;
  assign err     = sel ? errB  : errA;
  assign curAddr = sel ? 16'(addrB) : 16'(addrA);
  assign curData = sel ? wdataB : wdataA;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every RAM write strobe from either instance must match the head of the scoreboard.
  always @(negedge clk) begin
    if (weA === 1'b1 || weB === 1'b1) begin
      checkOutput("write_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        checkOutput("write_instance", 32'(weB), 32'(sel));
        checkOutput("ram_addr", 32'(curAddr), 32'(e.addr));
        checkOutput("ram_wdata", 32'(curData), 32'(e.data));
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waited = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rdy !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (rdy !== 1'b1) checkOutput("rx_ready_wait", 32'(rdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic checkResetState();
    checkOutput("rst_rx_ready", 32'(rdy), 32'd1);
    checkOutput("rst_ram_we", 32'(we), 32'd0);
    checkOutput("rst_ram_addr", 32'(curAddr), 32'd0);
    checkOutput("rst_ram_wdata", 32'(curData), 32'd0);
    checkOutput("rst_cpu_reset", 32'(cpu), 32'd1);
    checkOutput("rst_boot_done", 32'(done), 32'd0);
    checkOutput("rst_boot_error", 32'(err), 32'd0);
  endtask

  task automatic sendFrame(input logic [15:0] w[$], input bit badCs, input int gap);
    logic [15:0] sum = 16'h0;
    logic [15:0] n = 16'(w.size());
    logic [7:0]  bytes[$];
    foreach (w[i]) begin
      q.push_back('{addr: 16'(i), data: w[i]});
      sum = sum + w[i];
      bytes.push_back(w[i][7:0]);
      bytes.push_back(w[i][15:8]);
    end
    if (badCs) sum = sum + 16'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
    bytes.push_back(sum[7:0]);
    bytes.push_back(sum[15:8]);
`endif
    applyStimulus(8'hA5, gap);
    applyStimulus(n[7:0], gap);
    applyStimulus(n[15:8], (bytes.size() == 0) ? 0 : gap);
    foreach (bytes[i]) applyStimulus(bytes[i], (i == bytes.size() - 1) ? 0 : gap);
    checkOutput("cpu_reset_at_last", 32'(cpu), 32'd1);
`ifndef BOOT_LOADER_CHECKSUM_EN
    if (w.size() != 0) checkOutput("ram_we_last", 32'(we), 32'd1);
`endif
    @(negedge clk);
    checkOutput("boot_done", 32'(done), 32'(!badCs));
    checkOutput("cpu_reset", 32'(cpu), 32'(badCs));
    checkOutput("boot_error", 32'(err), 32'(badCs));
    checkOutput("writes_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] ws[$];
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    sel      = 1'b0;

    doReset();
    checkResetState();

    // Two-word image, back-to-back bytes.
    ws.delete(); ws.push_back(16'h1234); ws.push_back(16'h5678);
    sendFrame(ws, 1'b0, 0);

    // Bytes offered in RUN are refused.
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("run_rx_ready", 32'(rdy), 32'd0);
      checkOutput("run_boot_done", 32'(done), 32'd1);
    end
    rx_valid = 1'b0;

    // Leading junk plus gaps between every byte.
    doReset();
    applyStimulus(8'h00, 3);
    applyStimulus(8'hFF, 3);
    ws.delete(); ws.push_back(16'hABCD);
    sendFrame(ws, 1'b0, 3);

    // Reset after two of three words: only two writes, then a clean boot.
    doReset();
    q.push_back('{addr: 16'd0, data: 16'h1111});
    q.push_back('{addr: 16'd1, data: 16'h2222});
    applyStimulus(8'hA5, 0); applyStimulus(8'h03, 0); applyStimulus(8'h00, 0);
    applyStimulus(8'h11, 0); applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0); applyStimulus(8'h22, 0);
    repeat (2) @(negedge clk);
    doReset();
    checkResetState();
    checkOutput("writes_before_abort", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
    ws.delete(); ws.push_back(16'h7777);
    sendFrame(ws, 1'b0, 0);

    // MEMWIDTH=4 instance: N=17 rejected, junk ignored, then recovery.
    sel = 1'b1;
    doReset();
    checkResetState();
    applyStimulus(8'hA5, 0); applyStimulus(8'h11, 0); applyStimulus(8'h00, 0);
    checkOutput("err_boot_error", 32'(err), 32'd1);
    checkOutput("err_cpu_reset", 32'(cpu), 32'd1);
    checkOutput("err_rx_ready", 32'(rdy), 32'd1);
    applyStimulus(8'h00, 0);
    checkOutput("err_after_junk", 32'(err), 32'd1);
    ws.delete();
    sendFrame(ws, 1'b0, 0);

    // Largest accepted image for MEMWIDTH=4.
    doReset();
    ws.delete();
    for (int i = 0; i < 16; i++) ws.push_back(16'h1000 + 16'(i));
    sendFrame(ws, 1'b0, 0);

`ifdef BOOT_LOADER_CHECKSUM_EN
    sel = 1'b0;
    doReset();
    ws.delete(); ws.push_back(16'h0001); ws.push_back(16'h0002);
    sendFrame(ws, 1'b0, 0);
    doReset();
    sendFrame(ws, 1'b1, 0);
    repeat (3) @(negedge clk);
    checkOutput("bad_cs_cpu_held", 32'(cpu), 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
